// File: rtl/cordic_cos_pipeline.sv
// Fully pipelined CORDIC cosine: float32 angle in, float32 cos out, Q1.19 internal datapath.
// Also holds the 8- and 32-bit leading-one priority encoders used by the fixed-to-float stage.

module priority_encoder8 (
    input  logic [7:0] i_data,
    output logic [2:0] o_index,
    output logic       o_valid
);
    always_comb begin
        o_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i_data[i]) o_index = 3'(i);
        end
    end

    assign o_valid = |i_data;
endmodule

module priority_encoder32 (
    input  logic [31:0] i_data,
    output logic [4:0]  o_index,
    output logic        o_valid
);
    logic [2:0] w_sub_index [4];
    logic [3:0] w_byte_valid;
    logic [2:0] w_byte_index;
    logic       w_any;

    // One encoder per byte, then a second-level encoder picks the highest non-empty byte.
    for (genvar g = 0; g < 4; g++) begin : g_byte
        priority_encoder8 u_pe8 (
            .i_data  (i_data[8*g +: 8]),
            .o_index (w_sub_index[g]),
            .o_valid (w_byte_valid[g])
        );
    end

    priority_encoder8 u_pe8_sel (
        .i_data  ({4'b0000, w_byte_valid}),
        .o_index (w_byte_index),
        .o_valid (w_any)
    );

    assign o_index = 5'({w_byte_index, w_sub_index[w_byte_index[1:0]]});
    assign o_valid = w_any;
endmodule

module cordic_cos_pipeline #(
    parameter int W      = 21,
    parameter int STAGES = 16
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic          clk_en,
    input  logic [31:0]   dataa,
    output logic [31:0]   result,
    output logic [4:0]    rotate_index_debug,
    output logic [W-1:0]  x_debug,
    output logic [W-1:0]  z_debug,
    output logic [W-1:0]  fixed_point_input_debug,
    output logic [7:0]    exponent_debug,
    output logic [W-1:0]  fixed_point_result_debug
);
    localparam int                  FRAC         = W - 2;
    localparam logic signed [W-1:0] K_GAIN       = W'(32'h4DBA8);
    localparam logic [W-1:0]        MAG_MAX      = {1'b0, {(W-1){1'b1}}};
    localparam logic [7:0]          EXP_SAT      = 8'd128;
    localparam logic [7:0]          EXP_MIN      = 8'(127 - FRAC);
    localparam logic [7:0]          SHIFT_BASE   = 8'(150 - FRAC);
    localparam logic [7:0]          EXP_OUT_BIAS = 8'(127 - FRAC);

    function automatic logic signed [W-1:0] atan_lut(input int idx);
        case (idx)
            0:       atan_lut = W'(411775);
            1:       atan_lut = W'(243084);
            2:       atan_lut = W'(128439);
            3:       atan_lut = W'(65198);
            4:       atan_lut = W'(32725);
            5:       atan_lut = W'(16379);
            6:       atan_lut = W'(8191);
            7:       atan_lut = W'(4096);
            8:       atan_lut = W'(2048);
            9:       atan_lut = W'(1024);
            10:      atan_lut = W'(512);
            11:      atan_lut = W'(256);
            12:      atan_lut = W'(128);
            13:      atan_lut = W'(64);
            14:      atan_lut = W'(32);
            15:      atan_lut = W'(16);
            default: atan_lut = '0;
        endcase
    endfunction

    // Float to Q1.19, truncating: mantissa 1.m scaled by 2^(e-127+FRAC-23).
    logic [7:0]          w_exp;
    logic [23:0]         w_mant24;
    logic [W-1:0]        w_in_mag;
    logic signed [W-1:0] w_fixed_in;

    assign w_exp    = dataa[30:23];
    assign w_mant24 = {1'b1, dataa[22:0]};

    always_comb begin
        w_in_mag = '0;
        if (w_exp >= EXP_SAT) begin
            w_in_mag = MAG_MAX;
        end else if (w_exp >= EXP_MIN) begin
            w_in_mag = W'(w_mant24 >> (SHIFT_BASE - w_exp));
        end
    end

    assign w_fixed_in = dataa[31] ? -$signed(w_in_mag) : $signed(w_in_mag);

    logic signed [W-1:0] r_x     [STAGES];
    logic signed [W-1:0] r_y     [STAGES];
    logic signed [W-1:0] r_z     [STAGES];
    logic signed [W-1:0] w_x_in  [STAGES];
    logic signed [W-1:0] w_y_in  [STAGES];
    logic signed [W-1:0] w_z_in  [STAGES];
    logic signed [W-1:0] w_x_nxt [STAGES];
    logic signed [W-1:0] w_y_nxt [STAGES];
    logic signed [W-1:0] w_z_nxt [STAGES];

    always_comb begin
        w_x_in[0] = K_GAIN;
        w_y_in[0] = '0;
        w_z_in[0] = w_fixed_in;
        for (int i = 1; i < STAGES; i++) begin
            w_x_in[i] = r_x[i-1];
            w_y_in[i] = r_y[i-1];
            w_z_in[i] = r_z[i-1];
        end
    end

    // Rotate towards z=0: negative residual rotates back (d=-1), otherwise forward.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            if (w_z_in[i][W-1]) begin
                w_x_nxt[i] = w_x_in[i] + (w_y_in[i] >>> i);
                w_y_nxt[i] = w_y_in[i] - (w_x_in[i] >>> i);
                w_z_nxt[i] = w_z_in[i] + atan_lut(i);
            end else begin
                w_x_nxt[i] = w_x_in[i] - (w_y_in[i] >>> i);
                w_y_nxt[i] = w_y_in[i] + (w_x_in[i] >>> i);
                w_z_nxt[i] = w_z_in[i] - atan_lut(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < STAGES; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_z[i] <= '0;
            end
        end else if (clk_en) begin
            for (int i = 0; i < STAGES; i++) begin
                r_x[i] <= w_x_nxt[i];
                r_y[i] <= w_y_nxt[i];
                r_z[i] <= w_z_nxt[i];
            end
        end
    end

    // Fixed to float: normalise the magnitude so its leading one lands on the hidden bit.
    logic signed [W-1:0] w_x_out;
    logic [W-1:0]        w_x_abs;
    logic [4:0]          w_lead;
    logic                w_lead_valid;
    logic [4:0]          w_norm_shift;
    logic [W-1:0]        w_norm;

    assign w_x_out = r_x[STAGES-1];
    assign w_x_abs = w_x_out[W-1] ? -w_x_out : w_x_out;

    priority_encoder32 u_lead_one (
        .i_data  ({{(32-W){1'b0}}, w_x_abs}),
        .o_index (w_lead),
        .o_valid (w_lead_valid)
    );

    assign w_norm_shift = 5'(W - 1) - w_lead;
    assign w_norm       = w_x_abs << w_norm_shift;

    assign result = w_lead_valid
                  ? {w_x_out[W-1], EXP_OUT_BIAS + 8'(w_lead), w_norm[W-2:0], {(24-W){1'b0}}}
                  : 32'h0;

    assign rotate_index_debug       = 5'(STAGES - 1);
    assign x_debug                  = r_x[STAGES-1];
    assign z_debug                  = r_z[STAGES-1];
    assign fixed_point_input_debug  = w_fixed_in;
    assign exponent_debug           = dataa[30:23];
    assign fixed_point_result_debug = r_x[STAGES-1];
endmodule

// File: tb/tb_cordic_cos_pipeline.sv
// Self-checking bench for cordic_cos_pipeline: random angles scored against real-valued cos().
// Also exercises the priority encoders directly.

module tb_cordic_cos_pipeline;
    localparam int  STAGES = 16;
    localparam real TOL    = 1.0e-4;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic [31:0] dataa;
    logic [31:0] result;
    logic [4:0]  rotate_index_debug;
    logic [20:0] x_debug;
    logic [20:0] z_debug;
    logic [20:0] fixed_point_input_debug;
    logic [7:0]  exponent_debug;
    logic [20:0] fixed_point_result_debug;

    logic [31:0] pe32_in;
    logic [4:0]  pe32_idx;
    logic        pe32_valid;
    logic [7:0]  pe8_in;
    logic [2:0]  pe8_idx;
    logic        pe8_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Angles in flight, oldest first; out_state: 0 = result must be zero, 1 = cos known, 2 = unsupported.
    logic [31:0] exp_q[$];
    int          out_state;
    real         last_exp;

    always #5 clock = ~clock;

    cordic_cos_pipeline dut (
        .clock                    (clock),
        .aclr                     (aclr),
        .clk_en                   (clk_en),
        .dataa                    (dataa),
        .result                   (result),
        .rotate_index_debug       (rotate_index_debug),
        .x_debug                  (x_debug),
        .z_debug                  (z_debug),
        .fixed_point_input_debug  (fixed_point_input_debug),
        .exponent_debug           (exponent_debug),
        .fixed_point_result_debug (fixed_point_result_debug)
    );

    priority_encoder32 u_pe32 (.i_data(pe32_in), .o_index(pe32_idx), .o_valid(pe32_valid));
    priority_encoder8  u_pe8  (.i_data(pe8_in),  .o_index(pe8_idx),  .o_valid(pe8_valid));

    task automatic check_val(input string tag, input real obs, input real exp, input real tol);
        n_checks++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_fail++;
            $display("FAIL %s: got %0.6f expected %0.6f (tol %0.6f)", tag, obs, exp, tol);
        end
    endtask

    function automatic real f32_to_real(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int k = 127; k < e; k++) v = v * 2.0;
        for (int k = e; k < 127; k++) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    function automatic real abs_r(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Q1.19 truncation of the true angle, saturating at magnitude 2^20-1.
    function automatic real model_fixed(input logic [31:0] b);
        real a;
        real mag;
        a   = f32_to_real(b);
        mag = (abs_r(a) >= 2.0) ? 1048575.0 : $floor(abs_r(a) * 524288.0);
        return (a < 0.0) ? -mag : mag;
    endfunction

    function automatic logic [31:0] rand_angle();
        logic [31:0] b;
        int          sel;
        sel = int'($urandom_range(0, 19));
        if (sel == 0)      b = 32'h3F800000;
        else if (sel == 1) b = {1'b0, 8'($urandom_range(1, 107)), 23'($urandom)};
        else               b = {1'b0, 8'($urandom_range(108, 126)), 23'($urandom)};
        return b;
    endfunction

    task automatic step(input bit rst, input bit en, input logic [31:0] d);
        real a;
        @(negedge clock);
        aclr   = rst;
        clk_en = en;
        dataa  = d;
        #1;
        check_val("fixed_in", real'($signed(fixed_point_input_debug)), model_fixed(d), 0.0);
        check_val("exp_dbg", real'(exponent_debug), real'(d[30:23]), 0.0);
        @(posedge clock);
        #1;
        if (rst) begin
            exp_q.delete();
            out_state = 0;
            check_val("rst_result", real'(result), 0.0, 0.0);
            check_val("rst_x", real'(x_debug), 0.0, 0.0);
            check_val("rst_z", real'(z_debug), 0.0, 0.0);
            check_val("rst_fxres", real'(fixed_point_result_debug), 0.0, 0.0);
        end else begin
            if (en) begin
                exp_q.push_back(d);
                if (exp_q.size() == STAGES) begin
                    a = f32_to_real(exp_q.pop_front());
                    if (abs_r(a) <= 1.5) begin
                        out_state = 1;
                        last_exp  = $cos(a);
                    end else begin
                        out_state = 2;
                    end
                end
            end
            if (out_state == 1) begin
                check_val(en ? "cos" : "stall_cos", f32_to_real(result), last_exp, TOL);
            end else if (out_state == 0) begin
                check_val("fill_result", real'(result), 0.0, 0.0);
                check_val("fill_x", real'(x_debug), 0.0, 0.0);
            end
        end
    endtask

    initial begin
        logic [31:0] stream_tbl [11];
        logic [31:0] special_tbl [4];
        int          want_idx;
        stream_tbl = '{32'h00000000, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD,
                       32'h3F000000, 32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F666666,
                       32'h3F800000};
        special_tbl = '{32'hBF000000, 32'h40200000, 32'h33D6BF95, 32'h3FC00000};
        aclr      = 1'b1;
        clk_en    = 1'b0;
        dataa     = 32'h3F800000;
        out_state = 0;
        last_exp  = 0.0;

        step(1'b1, 1'b1, 32'h3F800000);
        step(1'b1, 1'b1, 32'h3F800000);
        check_val("rot_idx", real'(rotate_index_debug), 15.0, 0.0);

        // Single zero angle, then a back-to-back stream of the table.
        step(1'b0, 1'b1, 32'h00000000);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, stream_tbl[i]);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rand_angle());
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, rand_angle());
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, rand_angle());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, special_tbl[i]);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rand_angle());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rand_angle());

        // Reset with the pipeline full and clk_en low: reset must still win.
        step(1'b1, 1'b0, rand_angle());
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, rand_angle());
        for (int i = 0; i < 5; i++) step(1'b0, ($urandom_range(0, 1) == 1), rand_angle());
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, rand_angle());

        @(negedge clock);
        clk_en = 1'b0;
        dataa  = 32'h3F000000;
        #1;
        check_val("fixed_half", real'(fixed_point_input_debug), 262144.0, 0.0);

        pe32_in = 32'h00080000;
        pe8_in  = 8'h81;
        #1;
        check_val("pe32_idx", real'(pe32_idx), 19.0, 0.0);
        check_val("pe32_valid", real'(pe32_valid), 1.0, 0.0);
        check_val("pe8_idx", real'(pe8_idx), 7.0, 0.0);
        check_val("pe8_valid", real'(pe8_valid), 1.0, 0.0);
        pe32_in = 32'h0;
        pe8_in  = 8'h0;
        #1;
        check_val("pe32_zero_valid", real'(pe32_valid), 0.0, 0.0);
        check_val("pe32_zero_idx", real'(pe32_idx), 0.0, 0.0);
        check_val("pe8_zero_valid", real'(pe8_valid), 0.0, 0.0);
        for (int n = 0; n < 12; n++) begin
            pe32_in = $urandom >> $urandom_range(0, 31);
            pe8_in  = 8'($urandom_range(1, 255));
            #1;
            want_idx = 0;
            for (int b = 0; b < 32; b++) if (pe32_in[b]) want_idx = b;
            check_val("pe32_rand", real'(pe32_idx), real'(want_idx), 0.0);
            check_val("pe32_rand_valid", real'(pe32_valid), (pe32_in != 0) ? 1.0 : 0.0, 0.0);
            want_idx = 0;
            for (int b = 0; b < 8; b++) if (pe8_in[b]) want_idx = b;
            check_val("pe8_rand", real'(pe8_idx), real'(want_idx), 0.0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
